fp_add_issue: RTL and testbench

- Front-end initiator for fp_add_sub.
- Accepts add/sub requests from the FP scheduler and resolves dynamic rounding.
- Drives fp_add_sub's start/operand port and tracks each op's ROB tag through the unit's fixed latency.
- Buffers returning results in a small FIFO so the writeback port can apply backpressure, which fp_add_sub itself cannot absorb.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fp_res_fifo.sv | 68 ++++++
 rtl/fp_add_issue.sv | 162 ++++++++++++++++
 tb/tb_fp_add_issue.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_pkg: rounding-mode constants, writeback entry type, rm resolution  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fp_pkg;

  localparam int FP_RV    = 64;
  localparam int FP_TAG_W = 6;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;
  localparam logic [2:0] DYN = 3'd7;

  typedef struct packed {
    logic [FP_TAG_W-1:0] tag;
    logic [FP_RV-1:0]    res;
    logic                nv;
    logic                illegal;
  } fp_wb_t;

  // Returns {illegal, rm}; reserved modes fall back to RTZ so the op still issues.
  function automatic logic [3:0] resolve_rm(input logic [2:0] rnd, input logic [2:0] frm);
    logic [2:0] eff;
    eff = (rnd == DYN) ? frm : rnd;
    if (eff > RMM) begin
      return {1'b1, RTZ};
    end
    return {1'b0, eff};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_res_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_res_fifo: result FIFO with synchronous flush and occupancy count   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LAST = DEPTH - 1;
  localparam logic [AW:0]   c_full = DEPTH[AW:0];
  localparam logic [AW-1:0] c_last = LAST[AW-1:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == c_full);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);
  assign overflow  = push && w_full && !w_do_pop;
  assign pop_data  = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_add_issue: issues add/sub ops to fp_add_sub, tracks tags, buffers   |
// | results for a backpressured writeback port.  Rev 1.0                 |
// +----------------------------------------------------------------------+
module fp_add_issue
  import fp_pkg::*;
#(
  parameter int RV      = FP_RV,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = FP_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_sz,
  input  logic             req_sub,
  input  logic [2:0]       req_rnd,
  input  logic [RV-1:0]    req_in_1,
  input  logic [RV-1:0]    req_in_2,
  input  logic [2:0]       frm,
  input  logic             flush,
  output logic             fa_start,
  output logic             fa_sz,
  output logic             fa_sub,
  output logic [2:0]       fa_rnd,
  output logic [RV-1:0]    fa_in_1,
  output logic [RV-1:0]    fa_in_2,
  input  logic             fa_valid,
  input  logic             fa_exception,
  input  logic [RV-1:0]    fa_res,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [TAG_W-1:0] wb_tag,
  output logic [RV-1:0]    wb_res,
  output logic             wb_nv,
  output logic             wb_illegal,
  output logic             sticky_nv,
  input  logic             flags_clr,
  output logic             err_proto
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + LATENCY + 1);
  localparam logic [CNT_W-1:0] c_depth = DEPTH[CNT_W-1:0];

  logic             r_live [LATENCY];
  logic             r_busy [LATENCY];
  logic [TAG_W-1:0] r_tag  [LATENCY];
  logic             r_ill  [LATENCY];

  logic             w_accept;
  logic             w_ill;
  logic [2:0]       w_rm;
  logic [CNT_W-1:0] w_inflight;
  logic [CNT_W-1:0] w_outstanding;
  logic [AW:0]      w_fifo_count;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_overflow;
  fp_wb_t           w_push_data;
  fp_wb_t           w_head;
  logic             r_sticky_nv;
  logic             r_err_proto;

  assign {w_ill, w_rm} = resolve_rm(req_rnd, frm);

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_live[i]);
    end
  end

  assign w_outstanding = w_inflight + CNT_W'(w_fifo_count);
  assign req_ready     = !reset && !flush && (w_outstanding < c_depth);
  assign w_accept      = req_valid && req_ready;

  assign fa_start = w_accept;
  assign fa_sz    = req_sz;
  assign fa_sub   = req_sub;
  assign fa_rnd   = w_rm;
  assign fa_in_1  = req_in_1;
  assign fa_in_2  = req_in_2;

  // live drops on flush so killed results are discarded; busy survives the
  // flush so the unit's late fa_valid for a killed op is still expected.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_live[i] <= 1'b0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
        r_ill[i]  <= 1'b0;
      end
    end else begin
      r_live[0] <= w_accept;
      r_busy[0] <= w_accept;
      r_tag[0]  <= req_tag;
      r_ill[0]  <= w_ill;
      for (int i = 1; i < LATENCY; i++) begin
        r_live[i] <= r_live[i-1] && !flush;
        r_busy[i] <= r_busy[i-1];
        r_tag[i]  <= r_tag[i-1];
        r_ill[i]  <= r_ill[i-1];
      end
    end
  end

  assign w_push = fa_valid && r_live[LATENCY-1] && !flush;

  always_comb begin
    w_push_data         = '0;
    w_push_data.tag     = r_tag[LATENCY-1];
    w_push_data.res     = fa_res;
    w_push_data.nv      = fa_exception;
    w_push_data.illegal = r_ill[LATENCY-1];
  end

  fp_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fp_wb_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_empty),
    .count     (w_fifo_count),
    .overflow  (w_overflow)
  );

  assign w_pop      = !w_empty && wb_ready;
  assign wb_valid   = !w_empty;
  assign wb_tag     = w_head.tag;
  assign wb_res     = w_head.res;
  assign wb_nv      = w_head.nv;
  assign wb_illegal = w_head.illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_nv <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      if (w_pop && w_head.nv) r_sticky_nv <= 1'b1;
      else if (flags_clr)     r_sticky_nv <= 1'b0;
      if ((fa_valid ^ r_busy[LATENCY-1]) || w_overflow) r_err_proto <= 1'b1;
    end
  end

  assign sticky_nv = r_sticky_nv;
  assign err_proto = r_err_proto;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_issue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_add_issue: scoreboard bench with a behavioural fp_add_sub model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fp_add_issue;

  localparam int RV      = 64;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 6;

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_sz, req_sub, flush;
  logic fa_start, fa_sz, fa_sub, fa_valid, fa_exception;
  logic wb_valid, wb_ready, wb_nv, wb_illegal, sticky_nv, flags_clr, err_proto;
  logic force_fv;
  logic [TAG_W-1:0] req_tag, wb_tag;
  logic [2:0]       req_rnd, frm, fa_rnd;
  logic [RV-1:0]    req_in_1, req_in_2, fa_in_1, fa_in_2, fa_res, wb_res;

  always #5 clk = ~clk;

  fp_add_issue #(.RV(RV), .LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_sz(req_sz), .req_sub(req_sub), .req_rnd(req_rnd),
    .req_in_1(req_in_1), .req_in_2(req_in_2), .frm(frm), .flush(flush),
    .fa_start(fa_start), .fa_sz(fa_sz), .fa_sub(fa_sub), .fa_rnd(fa_rnd),
    .fa_in_1(fa_in_1), .fa_in_2(fa_in_2), .fa_valid(fa_valid),
    .fa_exception(fa_exception), .fa_res(fa_res), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_res(wb_res), .wb_nv(wb_nv),
    .wb_illegal(wb_illegal), .sticky_nv(sticky_nv), .flags_clr(flags_clr),
    .err_proto(err_proto)
  );

  // ---------------- behavioural fp_add_sub ----------------
  function automatic logic is_nan(input logic sz, input logic [63:0] x);
    if (sz) return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [63:0] f2d(input logic [31:0] s);
    logic [10:0] e;
    e = (s[30:23] == 8'd0) ? 11'd0 : ({3'b000, s[30:23]} + 11'd896);
    return {s[31], e, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [63:0] unit_res(input logic sz, input logic sub,
                                           input logic [63:0] a, input logic [63:0] b);
    real ra, rb, rr;
    logic [63:0] d;
    if (is_nan(sz, a) || is_nan(sz, b)) return 64'hFFF0000000000001;
    ra = $bitstoreal(sz ? a : f2d(a[31:0]));
    rb = $bitstoreal(sz ? b : f2d(b[31:0]));
    rr = sub ? (ra - rb) : (ra + rb);
    d  = $realtobits(rr);
    return sz ? d : {32'hFFFFFFFF, d2f(d)};
  endfunction

  logic [LATENCY-1:0] u_v;
  logic [RV-1:0]      u_res [LATENCY];
  logic               u_exc [LATENCY];

  always @(posedge clk) begin
    if (reset) begin
      u_v <= '0;
    end else begin
      u_v      <= {u_v[LATENCY-2:0], fa_start};
      u_res[0] <= unit_res(fa_sz, fa_sub, fa_in_1, fa_in_2);
      u_exc[0] <= is_nan(fa_sz, fa_in_1) || is_nan(fa_sz, fa_in_2);
      for (int i = 1; i < LATENCY; i++) begin
        u_res[i] <= u_res[i-1];
        u_exc[i] <= u_exc[i-1];
      end
    end
  end

  assign fa_valid     = u_v[LATENCY-1] | force_fv;
  assign fa_res       = u_res[LATENCY-1];
  assign fa_exception = u_exc[LATENCY-1];

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [63:0]      res;
    logic             nv;
    logic             ill;
    int               cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic m_sticky = 1'b0;
  logic exp_err  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] eff, exp_rm;
    logic       exp_ill, popped, pop_nv;
    if (reset) begin
      q.delete();
      m_sticky = 1'b0;
    end else begin
      cyc++;
      popped = 1'b0;
      pop_nv = 1'b0;
      check("req_ready", req_ready, 64'(!flush && (q.size() < DEPTH)));
      check("sticky_nv", sticky_nv, m_sticky);
      check("err_proto", err_proto, exp_err);
      check("fa_start", fa_start, req_valid && req_ready);
      if (q.size() == 0) check("wb_valid_empty", wb_valid, 0);
      if (wb_valid && wb_ready && q.size() > 0) begin
        e = q.pop_front();
        popped = 1'b1;
        pop_nv = e.nv;
        check("wb_tag", wb_tag, e.tag);
        check("wb_res", wb_res, e.res);
        check("wb_nv", wb_nv, e.nv);
        check("wb_illegal", wb_illegal, e.ill);
        check("wb_latency", 64'((cyc - e.cyc) >= LATENCY + 1), 1);
      end
      if (flush) q.delete();
      if (req_valid && req_ready) begin
        eff     = (req_rnd == 3'd7) ? frm : req_rnd;
        exp_ill = (eff >= 3'd5);
        exp_rm  = exp_ill ? 3'd1 : eff;
        check("fa_rnd", fa_rnd, exp_rm);
        e.tag = req_tag;
        e.res = unit_res(req_sz, req_sub, req_in_1, req_in_2);
        e.nv  = is_nan(req_sz, req_in_1) || is_nan(req_sz, req_in_2);
        e.ill = exp_ill;
        e.cyc = cyc;
        q.push_back(e);
      end
      if (popped && pop_nv) m_sticky = 1'b1;
      else if (flags_clr)   m_sticky = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [TAG_W-1:0] tag, input logic sz, input logic sub,
                       input logic [2:0] rnd, input logic [63:0] a, input logic [63:0] b);
    logic ok;
    req_tag = tag; req_sz = sz; req_sub = sub; req_rnd = rnd;
    req_in_1 = a; req_in_2 = b; req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    check("issue_accepted", ok, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (wb_valid) begin n = k; break; end
    end
    check("wb_arrived", 64'(n != 0), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nacc, seen_old, seen_new;
    reset = 1'b1; req_valid = 1'b1; req_tag = '0; req_sz = 1'b0; req_sub = 1'b0;
    req_rnd = 3'd0; req_in_1 = '0; req_in_2 = '0; frm = 3'd0; flush = 1'b0;
    wb_ready = 1'b0; flags_clr = 1'b0; force_fv = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_fa_start", fa_start, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_sticky_nv", sticky_nv, 0);
    check("rst_err_proto", err_proto, 0);
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b0;
    idle(2);

    // double add 1.0 + 2.0
    wb_ready = 1'b1;
    issue(6'd5, 1'b1, 1'b0, 3'd0, 64'h3FF0000000000000, 64'h4000000000000000);
    wait_wb(n);
    check("dadd_latency", n, 3);
    check("dadd_res", wb_res, 64'h4008000000000000);
    check("dadd_tag", wb_tag, 5);
    check("dadd_nv", wb_nv, 0);
    idle(3);

    // single sub 3.0 - 1.0, NaN-boxed
    issue(6'd6, 1'b0, 1'b1, 3'd0, 64'hFFFFFFFF40400000, 64'hFFFFFFFF3F800000);
    wait_wb(n);
    check("ssub_res", wb_res, 64'hFFFFFFFF40000000);
    idle(3);

    // backpressure
    wb_ready = 1'b0; nacc = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; req_tag = 6'(10 + nacc); req_sz = 1'b1; req_rnd = 3'd0;
      req_in_1 = {$urandom, $urandom}; req_in_2 = {$urandom, $urandom};
      @(negedge clk);
      if (req_ready) nacc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("bp_accepted", nacc, 4);
    idle(3);
    @(negedge clk);
    check("bp_full_ready", req_ready, 0);
    check("bp_full_valid", wb_valid, 1);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle_ready", req_ready, 0);
    @(negedge clk);
    check("bp_after_pop_ready", req_ready, 1);
    @(posedge clk); #1;
    idle(6);

    // flush with two ops in flight
    req_valid = 1'b1; req_tag = 6'd1; req_sz = 1'b1; req_sub = 1'b0; req_rnd = 3'd0;
    req_in_1 = 64'h3FF0000000000000; req_in_2 = 64'h3FF0000000000000;
    @(negedge clk);
    check("fl_acc1", req_ready, 1);
    @(posedge clk); #1;
    req_tag = 6'd2;
    @(negedge clk);
    check("fl_acc2", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fl_ready_low", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    issue(6'd3, 1'b1, 1'b0, 3'd0, 64'h4000000000000000, 64'h4000000000000000);
    seen_old = 0; seen_new = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wb_valid && (wb_tag == 6'd1 || wb_tag == 6'd2)) seen_old++;
      if (wb_valid && wb_tag == 6'd3) seen_new++;
    end
    check("fl_killed_seen", seen_old, 0);
    check("fl_new_seen", seen_new, 1);
    check("fl_err_proto", err_proto, 0);
    @(posedge clk); #1;

    // dynamic illegal rounding and NV
    frm = 3'd6;
    issue(6'd7, 1'b1, 1'b0, 3'd7, 64'h7FF8000000000000, 64'h3FF0000000000000);
    wait_wb(n);
    check("rm_illegal", wb_illegal, 1);
    check("rm_nv", wb_nv, 1);
    check("rm_res", wb_res, 64'hFFF0000000000001);
    @(posedge clk); #1;
    @(negedge clk);
    check("nv_sticky_set", sticky_nv, 1);
    @(posedge clk); #1;
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    @(negedge clk);
    check("nv_sticky_clr", sticky_nv, 0);
    @(posedge clk); #1;
    frm = 3'd0;

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_valid = ($urandom % 4) != 0;
      req_tag   = 6'($urandom);
      req_sz    = 1'($urandom);
      req_sub   = 1'($urandom);
      req_rnd   = 3'($urandom);
      frm       = 3'($urandom);
      req_in_1  = req_sz ? {$urandom, $urandom} : {32'hFFFFFFFF, $urandom};
      req_in_2  = req_sz ? {$urandom, $urandom} : {32'hFFFFFFFF, $urandom};
      if (($urandom % 8) == 0) req_in_1 = req_sz ? 64'h7FF8000000000000 : 64'hFFFFFFFF7FC00000;
      wb_ready  = ($urandom % 10) < 7;
      flush     = ($urandom % 40) == 0;
      flags_clr = ($urandom % 16) == 0;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; flags_clr = 1'b0; wb_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);
    idle(5);

    // fa_valid with nothing in flight
    force_fv = 1'b1;
    @(posedge clk); #1;
    force_fv = 1'b0; exp_err = 1'b1;
    repeat (4) @(negedge clk);
    check("proto_held", err_proto, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0; exp_err = 1'b0;
    @(negedge clk);
    check("proto_cleared", err_proto, 0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
